// File: rtl/mips_16_arb_pkg.sv
// Shared constants and grant encoding for the mips_16 data-memory port arbiter.
// The MEM stage uses the same data/address widths.
package mips_16_arb_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned ADDR_W           = 16;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_CNT_W        = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the arbiter: pipeline MEM-stage side, host/debug side and the RAM port.
// The master modport is the surrounding system; the slave modport is the arbiter.
interface dmem_port_arbiter_if;

  logic                                  pipe_req;
  logic                                  pipe_we;
  logic [mips_16_arb_pkg::ADDR_W-1:0]    pipe_addr;
  logic [mips_16_arb_pkg::DATA_W-1:0]    pipe_wdata;
  logic [mips_16_arb_pkg::DATA_W-1:0]    pipe_rdata;
  logic                                  pipe_stall;

  logic                                  host_valid;
  logic                                  host_ready;
  logic                                  host_we;
  logic [mips_16_arb_pkg::ADDR_W-1:0]    host_addr;
  logic [mips_16_arb_pkg::DATA_W-1:0]    host_wdata;
  logic                                  host_rvalid;
  logic [mips_16_arb_pkg::DATA_W-1:0]    host_rdata;

  logic [mips_16_arb_pkg::ADDR_W-1:0]    mem_addr;
  logic [mips_16_arb_pkg::DATA_W-1:0]    mem_wdata;
  logic                                  mem_we;
  logic [mips_16_arb_pkg::DATA_W-1:0]    mem_rdata;

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  pipe_rdata, pipe_stall,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output pipe_rdata, pipe_stall,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter with synchronous clear; flags when the limit is reached.
module arb_starve_cnt #(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_at_limit = (r_cnt == Limit);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the pipeline MEM stage (priority, zero latency)
// and a host requester, with a starvation counter that forces a host grant after a bounded wait.
module dmem_port_arbiter
  import mips_16_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus
);

  logic              w_at_limit;
  logic              w_gnt_host;
  logic              w_gnt_pipe;
  logic              w_host_rd;
  gnt_e              w_gnt;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  // Host wins when the pipeline is idle or has been holding the host off long enough.
  assign w_gnt_host = !rst && bus.host_valid && (!bus.pipe_req || w_at_limit);
  assign w_gnt_pipe = !rst && bus.pipe_req && !w_gnt_host;
  assign w_host_rd  = w_gnt_host && !bus.host_we;

  arb_starve_cnt #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (bus.host_valid && bus.pipe_req && !w_gnt_host),
    .i_clr      (w_gnt_host || !bus.host_valid),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_gnt_host) begin
      w_gnt = GNT_HOST;
    end else if (w_gnt_pipe) begin
      w_gnt = GNT_PIPE;
    end
  end

  always_comb begin
    bus.mem_addr  = bus.pipe_addr;
    bus.mem_wdata = bus.pipe_wdata;
    bus.mem_we    = 1'b0;
    unique case (w_gnt)
      GNT_HOST: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_we    = bus.host_we;
      end
      GNT_PIPE: bus.mem_we = bus.pipe_we;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.host_ready  = w_gnt_host;
  assign bus.pipe_stall  = bus.pipe_req && w_gnt_host;
  assign bus.pipe_rdata  = bus.mem_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;

endmodule
